// File: rtl/lake_harness_pkg.sv
// Shared types and sizing helpers for the Lake tile run controller.
package lake_harness_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_GAP   = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int CFG_WORD_W = 32;

    function automatic int num_words(input int config_width);
        return (config_width + CFG_WORD_W - 1) / CFG_WORD_W;
    endfunction

    // Word-address width; kept at least one bit so a single-word config still has a port.
    function automatic int addr_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/lake_cfg_word_reg.sv
// Wide config register loaded one 32-bit word at a time; the top word is
// truncated to CONFIG_WIDTH and addresses past the last word match nothing.
module lake_cfg_word_reg
    import lake_harness_pkg::*;
#(
    parameter  int CONFIG_WIDTH = 550,
    localparam int NUM_WORDS    = num_words(CONFIG_WIDTH),
    localparam int CFG_AW       = addr_width(NUM_WORDS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [CFG_AW-1:0]       addr,
    input  logic [CFG_WORD_W-1:0]   data,
    output logic [CONFIG_WIDTH-1:0] cfg
);

    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
        localparam int LO = k * CFG_WORD_W;
        localparam int W  = (CONFIG_WIDTH - LO < CFG_WORD_W) ? CONFIG_WIDTH - LO : CFG_WORD_W;

        logic [W-1:0] word_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                word_q <= '0;
            end else if (wr_en && addr == CFG_AW'(k)) begin
                word_q <= data[W-1:0];
            end
        end

        assign cfg[LO +: W] = word_q;
    end

endmodule

// File: rtl/lake_harness_ctrl.sv
// Run controller for a static Lake tile: config load, flush window, ramp
// stimulus and one-cycle-latency output capture.
//
//   state | meaning
//   IDLE  | after reset, config writes accepted, waiting for start
//   FLUSH | flush_out high for FLUSH_CYCLES cycles
//   GAP   | one quiet cycle, flush low and stimulus zero
//   RUN   | ramp stimulus for NUM_CYCLES cycles, capture each cycle
//   DONE  | run finished, stimulus held, config writes accepted
module lake_harness_ctrl
    import lake_harness_pkg::*;
#(
    parameter  int DATA_WIDTH   = 16,
    parameter  int CONFIG_WIDTH = 550,
    parameter  int NUM_IN       = 1,
    parameter  int NUM_OUT      = 1,
    parameter  int FLUSH_CYCLES = 10,
    parameter  int NUM_CYCLES   = 1000,
    parameter  int STRIDE       = 2,
    localparam int NUM_WORDS    = num_words(CONFIG_WIDTH),
    localparam int CFG_AW       = addr_width(NUM_WORDS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_write,
    input  logic [CFG_AW-1:0]             cfg_addr,
    input  logic [CFG_WORD_W-1:0]         cfg_data,
    input  logic                          start,
    output logic [CONFIG_WIDTH-1:0]       config_out,
    output logic                          flush_out,
    output logic [NUM_IN*DATA_WIDTH-1:0]  dut_in,
    input  logic [NUM_OUT*DATA_WIDTH-1:0] dut_out,
    output logic                          cap_valid,
    output logic [31:0]                   cap_idx,
    output logic [NUM_OUT*DATA_WIDTH-1:0] cap_data,
    output logic [63:0]                   cycle_count,
    output logic                          busy,
    output logic                          done
);

    localparam int          IW         = NUM_IN * DATA_WIDTH;
    localparam int          OW         = NUM_OUT * DATA_WIDTH;
    localparam logic [31:0] FLUSH_LAST = 32'(FLUSH_CYCLES - 1);
    localparam logic [31:0] RUN_LAST   = 32'(NUM_CYCLES - 1);
    localparam logic [31:0] STRIDE_W   = 32'(STRIDE);

    state_t        state_q, state_d;
    logic [31:0]   flush_cnt_q, flush_cnt_d;
    logic [31:0]   idx_q, idx_d;
    logic [IW-1:0] dut_in_d;
    logic          cap_valid_d;
    logic [31:0]   cap_idx_d;
    logic [OW-1:0] cap_data_d;
    logic          cfg_we;

    // Port p of run cycle i carries i*STRIDE + p, wrapping at the port width.
    function automatic logic [IW-1:0] ramp(input logic [31:0] i);
        logic [IW-1:0] r;
        logic [31:0]   v;
        r = '0;
        for (int p = 0; p < NUM_IN; p++) begin
            v = i * STRIDE_W + 32'(p);
            r[p*DATA_WIDTH +: DATA_WIDTH] = v[DATA_WIDTH-1:0];
        end
        return r;
    endfunction

    assign cfg_we = cfg_write && (state_q == ST_IDLE || state_q == ST_DONE);

    lake_cfg_word_reg #(
        .CONFIG_WIDTH (CONFIG_WIDTH)
    ) u_cfg (
        .clk   (clk),
        .rst   (rst),
        .wr_en (cfg_we),
        .addr  (cfg_addr),
        .data  (cfg_data),
        .cfg   (config_out)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        idx_d       = idx_q;
        dut_in_d    = dut_in;
        cap_valid_d = 1'b0;
        cap_idx_d   = cap_idx;
        cap_data_d  = cap_data;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = FLUSH_LAST;
                    dut_in_d    = '0;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d  = ST_GAP;
                    dut_in_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 32'd1;
                end
            end
            ST_GAP: begin
                state_d  = ST_RUN;
                idx_d    = '0;
                dut_in_d = ramp(32'd0);
            end
            ST_RUN: begin
                // Capture lands the cycle after the RUN cycle it belongs to.
                cap_valid_d = 1'b1;
                cap_idx_d   = idx_q;
                cap_data_d  = dut_out;
                if (idx_q == RUN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d    = idx_q + 32'd1;
                    dut_in_d = ramp(idx_q + 32'd1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            idx_q       <= '0;
            flush_out   <= 1'b0;
            dut_in      <= '0;
            cap_valid   <= 1'b0;
            cap_idx     <= '0;
            cap_data    <= '0;
            cycle_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            idx_q       <= idx_d;
            flush_out   <= (state_d == ST_FLUSH);
            dut_in      <= dut_in_d;
            cap_valid   <= cap_valid_d;
            cap_idx     <= cap_idx_d;
            cap_data    <= cap_data_d;
            cycle_count <= cycle_count + 64'd1;
            busy        <= (state_d inside {ST_FLUSH, ST_GAP, ST_RUN});
            done        <= (state_d == ST_DONE);
        end
    end

endmodule

// File: doc/lake_harness_ctrl.md
Name: lake_harness_ctrl

Overview:
Synthesizable, parametrised run controller for static Lake memory tiles; replaces hand-sequenced bench stimulus.
- Loads a wide config word from a 32-bit addressed write bus.
- Sequences a flush window.
- Drives ramp stimulus on NUM_IN data ports for NUM_CYCLES cycles.
- Captures NUM_OUT output ports per cycle with an index for an external memory or checker.
- Sits between the bench/host and the DUT (lakespec-style tile).

Parameters:
DATA_WIDTH, 16, width of each data port
CONFIG_WIDTH, 550, width of DUT config vector
NUM_IN, 1, number of stimulus ports
NUM_OUT, 1, number of captured ports
FLUSH_CYCLES, 10, cycles flush_out is held high (>=1)
NUM_CYCLES, 1000, stimulus/capture cycles per run (>=1)
STRIDE, 2, ramp increment per cycle

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
cfg_write  in  1  config word write strobe
cfg_addr  in  CFG_AW  word index; CFG_AW = $clog2(NUM_WORDS), minimum 1; NUM_WORDS = ceil(CONFIG_WIDTH/32)
cfg_data  in  32  config word
start  in  1  run request pulse
config_out  out  CONFIG_WIDTH  config vector to DUT
flush_out  out  1  DUT flush
dut_in  out  NUM_IN*DATA_WIDTH  stimulus, port p in slice p
dut_out  in  NUM_OUT*DATA_WIDTH  DUT outputs
cap_valid  out  1  capture strobe
cap_idx  out  32  run-cycle index of capture
cap_data  out  NUM_OUT*DATA_WIDTH  captured outputs
cycle_count  out  64  cycles since reset
busy  out  1  high in FLUSH/GAP/RUN
done  out  1  high in DONE

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE. config_out=0, flush_out=0, dut_in=0, cap_valid=0, cap_idx=0, cap_data=0, cycle_count=0, busy=0, done=0. rst mid-run aborts immediately with the same values.
- cycle_count: +1 every non-reset cycle; wraps at 2^64.
- Config writes: accepted only in IDLE or DONE. Word k writes config_out[32k+31:32k]. The last word is truncated to CONFIG_WIDTH. Writes with cfg_addr >= NUM_WORDS are ignored. Write is visible on config_out the next cycle. Config persists across runs; only rst clears it.
- FSM (all outputs registered):
  - IDLE/DONE --start--> FLUSH. start in FLUSH/GAP/RUN is ignored.
  - FLUSH: flush_out=1 for exactly FLUSH_CYCLES cycles, then GAP.
  - GAP: one cycle, flush_out=0, dut_in=0. Then RUN with i=0.
  - RUN: for i=0..NUM_CYCLES-1, dut_in slice p = (i*STRIDE + p) mod 2^DATA_WIDTH. After i=NUM_CYCLES-1 → DONE.
  - DONE: done=1, dut_in holds its last value, config writes allowed.
- Capture: in the cycle after each RUN cycle i, cap_valid=1, cap_idx=i, cap_data = dut_out sampled at the end of RUN cycle i (one-cycle capture latency). The final capture (i=NUM_CYCLES-1) is asserted in the first DONE cycle. No capture occurs in FLUSH/GAP.
- Same-cycle cfg_write and start in IDLE: the write takes effect and the FSM enters FLUSH; config_out is updated when flush_out first rises.
- Ramp arithmetic is unsigned and wraps modulo 2^DATA_WIDTH. The index counter is 32-bit; NUM_CYCLES < 2^32.

Decomposition:
- Package lake_harness_pkg: state enum (IDLE, FLUSH, GAP, RUN, DONE); CFG_WORD_W=32 constant; function num_words(CONFIG_WIDTH).
- One sub-module, lake_cfg_word_reg: addressed 32-bit write into the wide register with truncation and address-range check.
- FSM, ramp generation and capture stay in the top level.

Test Plan:
- Config load, CONFIG_WIDTH=550: write words 0..17 with data=0xA5A50000|k. Required: config_out[31:0]=0xA5A50000, config_out[549:544]=0x11 (low 6 bits of word 17). A write to addr 18 changes nothing.
- Flush window, FLUSH_CYCLES=10: start pulse. Required: flush_out high for exactly 10 cycles starting the cycle after start, then low. First ramp value 0 appears two cycles after flush falls (GAP cycle, then RUN i=0).
- Ramp/capture with loopback (dut_out=dut_in), NUM_CYCLES=1000, STRIDE=2: required 1000 cap_valid pulses, cap_idx 0..999, cap_data=2*cap_idx; done rises with the last capture.
- Multi-port wrap, NUM_IN=3, DATA_WIDTH=8, STRIDE=100: at i=3, ports = 44, 45, 46.
- Reset mid-RUN at i=500: the next cycle shows all outputs at reset values (config_out=0, cycle_count=0) and state IDLE. A new start begins a fresh flush.
- Ignored inputs: cfg_write during RUN and a start pulse during FLUSH have no effect. start from DONE reruns with the retained config and cap_idx restarting at 0.
